// File: rtl/uart_mmio_responder_if.sv
// ---------------------------------------------------------------------------
// uart_mmio_responder_if
// Register-side bus between the MEM stage and the UART responder.
//   uart_wdata      : byte to transmit, valid with uart_write_ce
//   uart_write_ce   : 1-cycle transmit request
//   uart_rdata      : head of RX storage
//   clean_recv_flag : read-consume strobe (level, may be held)
//   recv_flag       : unread RX byte available
//   send_flag       : transmitter idle, accepts a byte
// master = MEM stage side, slave = UART responder side.
// ---------------------------------------------------------------------------
interface uart_mmio_responder_if;
  logic [7:0] uart_wdata;
  logic       uart_write_ce;
  logic [7:0] uart_rdata;
  logic       clean_recv_flag;
  logic       recv_flag;
  logic       send_flag;

  modport master (
    output uart_wdata,
    output uart_write_ce,
    output clean_recv_flag,
    input  uart_rdata,
    input  recv_flag,
    input  send_flag
  );

  modport slave (
    input  uart_wdata,
    input  uart_write_ce,
    input  clean_recv_flag,
    output uart_rdata,
    output recv_flag,
    output send_flag
  );
endinterface

// File: rtl/uart_mmio_responder.sv
// ---------------------------------------------------------------------------
// uart_mmio_responder
// Device end of the memory-stage UART port. Accepts single-byte transmit
// requests, serialises them as 8N1 (LSB first) on txd, deserialises 8N1 frames
// from rxd and presents the received byte with recv_flag/send_flag status.
//
// Ports
//   clk          : system clock, all logic on posedge
//   rst          : asynchronous active-low reset
//   bus          : uart_mmio_responder_if.slave register-side bus
//   txd          : serial out, idle high
//   rxd          : serial in, asynchronous to clk
//   rx_frame_err : 1-cycle pulse, stop bit sampled 0, byte discarded
//   rx_overrun   : 1-cycle pulse, byte arrived while storage was full
//
// Parameters
//   CLKS_PER_BIT  : clk cycles per serial bit (>= 4)
//   RX_FIFO_DEPTH : RX FIFO entries (power of 2), used with UART_RX_FIFO_EN
//
// Build option
//   UART_RX_FIFO_EN : when defined, RX storage is an RX_FIFO_DEPTH-entry FIFO
//                     (full-drop on overrun); otherwise a single holding
//                     register that is overwritten on overrun.
// ---------------------------------------------------------------------------
module uart_mmio_responder #(
  parameter int CLKS_PER_BIT  = 5208,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_mmio_responder_if.slave        bus,
  output logic                        txd,
  input  logic                        rxd,
  output logic                        rx_frame_err,
  output logic                        rx_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Elaboration-time guard on the parameter ranges the timing relies on.
  if (CLKS_PER_BIT < 4 || RX_FIFO_DEPTH < 1 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_mmio_responder: CLKS_PER_BIT must be >= 4 and RX_FIFO_DEPTH a power of 2");
  end

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             txd_q;
  logic             send_flag_q;
  logic             tx_last;

  assign tx_last = (tx_cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
      send_flag_q <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          // Requests outside IDLE fall through untouched: no queueing.
          if (bus.uart_write_ce) begin
            tx_shift_q  <= bus.uart_wdata;
            txd_q       <= 1'b0;
            send_flag_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_state_q  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_last) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              // Shift so the next bit to send is always tx_shift_q[0].
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              txd_q      <= tx_shift_q[1];
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_last) begin
            tx_cnt_q    <= '0;
            send_flag_q <= 1'b1;
            tx_state_q  <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_state_q  <= TX_IDLE;
          txd_q       <= 1'b1;
          send_flag_q <= 1'b1;
        end
      endcase
    end
  end

  assign txd           = txd_q;
  assign bus.send_flag = send_flag_q;

  // -------------------------------------------------------------------------
  // Receiver: 2-flop synchroniser, then frame FSM on the synchronised line
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic             rxd_meta_q;
  logic             rxd_sync_q;
  logic             rxd_prev_q;
  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_frame_err_q;
  logic             rx_last;
  logic             rx_push;

  assign rx_last = (rx_cnt_q == CNT_LAST);

  // A good stop-bit sample hands the completed byte straight to storage so
  // recv_flag is visible on the very next cycle.
  assign rx_push = (rx_state_q == RX_STOP) && rx_last && rxd_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q     <= 1'b1;
      rxd_sync_q     <= 1'b1;
      rxd_prev_q     <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rxd_meta_q     <= rxd;
      rxd_sync_q     <= rxd_meta_q;
      rxd_prev_q     <= rxd_sync_q;
      rx_frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rxd_prev_q && !rxd_sync_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          // Mid-start-bit check rejects short glitches; it also aligns all
          // later samples to bit centres.
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rxd_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_last) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_last) begin
            rx_cnt_q <= '0;
            if (rxd_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_frame_err_q <= 1'b1;
              rx_state_q     <= RX_WAIT;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_WAIT: begin
          // Hold off re-arming until the line is back at idle level.
          if (rxd_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_frame_err = rx_frame_err_q;

  // -------------------------------------------------------------------------
  // Consume strobe: only its rising edge pops, so a held strobe pops once
  // -------------------------------------------------------------------------
  logic clean_prev_q;
  logic rx_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) clean_prev_q <= 1'b0;
    else      clean_prev_q <= bus.clean_recv_flag;
  end

  assign rx_pop = bus.clean_recv_flag && !clean_prev_q;

  // -------------------------------------------------------------------------
  // RX storage
  // -------------------------------------------------------------------------
`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;

  logic [7:0]       fifo_mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             rx_overrun_q;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = rx_pop && (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push_ok = rx_push && ((count_q != (PTR_W+1)'(RX_FIFO_DEPTH)) || pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= rx_push && !push_ok;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end

  assign bus.recv_flag  = (count_q != '0);
  assign bus.uart_rdata = (count_q != '0) ? fifo_mem[rd_ptr_q] : 8'h00;
  assign rx_overrun     = rx_overrun_q;
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       rx_overrun_q, rx_overrun_d;

  always_comb begin
    hold_d       = hold_q;
    full_d       = full_q;
    rx_overrun_d = 1'b0;
    if (rx_pop) full_d = 1'b0;
    if (rx_push) begin
      // New byte always wins; it is an overrun only if the old one was unread.
      hold_d       = rx_shift_q;
      full_d       = 1'b1;
      rx_overrun_d = full_q && !rx_pop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q       <= 8'h00;
      full_q       <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      full_q       <= full_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign bus.recv_flag  = full_q;
  assign bus.uart_rdata = hold_q;
  assign rx_overrun     = rx_overrun_q;
`endif

endmodule

// File: tb/tb_uart_mmio_responder.sv
module tb_uart_mmio_responder;
  localparam int CPB = 8;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic txd, rxd, rx_frame_err, rx_overrun;

  always #5 clk = ~clk;

  uart_mmio_responder_if bus();

  uart_mmio_responder #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .txd          (txd),
    .rxd          (rxd),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ovr_cnt = 0;
  int exp_fe = 0;
  int exp_ovr = 0;
  logic [7:0] mq[$];

  // Pulse monitors: each high cycle counts once, so a stretched pulse shows.
  always @(posedge clk) begin
    if (rx_frame_err === 1'b1) fe_cnt++;
    if (rx_overrun === 1'b1) ovr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference storage: queue of unread bytes, capacity DEPTH.
  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else begin
      exp_ovr++;
      if (DEPTH == 1) mq[0] = b;
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_recv_flag"}, bus.recv_flag, (mq.size() != 0) ? 1 : 0);
    if (mq.size() != 0) check({tag, "_rdata"}, bus.uart_rdata, mq[0]);
    check({tag, "_overruns"}, ovr_cnt, exp_ovr);
    check({tag, "_frame_errs"}, fe_cnt, exp_fe);
  endtask

  // Sends one byte and checks the full txd waveform; optionally issues a
  // second write mid-frame that must be ignored.
  task automatic tx_frame(input logic [7:0] b, input bit inject);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    bus.uart_wdata    = b;
    bus.uart_write_ce = 1'b1;
    tick();
    bus.uart_write_ce = 1'b0;
    for (int k = 1; k <= 81; k++) begin
      if (k == 21) bus.uart_write_ce = 1'b0;
      if (k <= 80) begin
        check($sformatf("tx_txd_c%0d", k), txd, frame[(k-1)/CPB]);
        check($sformatf("tx_busy_c%0d", k), bus.send_flag, 0);
      end else begin
        check("tx_send_flag_back", bus.send_flag, 1);
        check("tx_txd_idle", txd, 1);
      end
      if (inject && k == 20) begin
        bus.uart_wdata    = 8'h3C;
        bus.uart_write_ce = 1'b1;
      end
      tick();
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = stop;
    repeat (CPB) tick();
    rxd = 1'b1;
    repeat (4) tick();
  endtask

  task automatic consume(input int hold);
    bus.clean_recv_flag = 1'b1;
    if (mq.size() != 0) check("rdata_stable_in_strobe", bus.uart_rdata, mq[0]);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (i == 0 && mq.size() != 0) void'(mq.pop_front());
      check($sformatf("consume_h%0d", i), bus.recv_flag, (mq.size() != 0) ? 1 : 0);
      if (mq.size() != 0) check("consume_rdata", bus.uart_rdata, mq[0]);
    end
    bus.clean_recv_flag = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] rb;
    int guard;
    rxd                 = 1'b1;
    bus.uart_wdata      = 8'h00;
    bus.uart_write_ce   = 1'b0;
    bus.clean_recv_flag = 1'b0;
    rst                 = 1'b0;
    repeat (3) tick();
    check("rst_txd", txd, 1);
    check("rst_send_flag", bus.send_flag, 1);
    check("rst_recv_flag", bus.recv_flag, 0);
    check("rst_rdata", bus.uart_rdata, 8'h00);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_overrun", rx_overrun, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Transmit: fixed pattern with an ignored mid-frame write, then random.
    tx_frame(8'hA5, 1'b1);
    repeat (3) tick();
    tx_frame(8'($urandom), 1'b0);
    repeat (3) tick();

    // Receive one byte, consume with a held strobe.
    rx_send(8'h5A, 1'b1);
    model_push(8'h5A);
    check_rx("rx_5a");
    consume(3);
    repeat (5) tick();
    check_rx("rx_after_consume");

    // Short low glitch must not start a reception.
    rxd = 1'b0;
    repeat (2) tick();
    rxd = 1'b1;
    repeat (100) tick();
    check_rx("glitch");

    // Bad stop bit: one frame-error pulse, nothing stored.
    rx_send(8'h33, 1'b0);
    exp_fe++;
    check_rx("frame_err");

    // Receiver recovers after a framing error.
    rb = 8'($urandom);
    rx_send(rb, 1'b1);
    model_push(rb);
    check_rx("rx_after_err");
    consume(1);

    // Two unread bytes.
    rx_send(8'h11, 1'b1);
    model_push(8'h11);
    rx_send(8'h22, 1'b1);
    model_push(8'h22);
    check_rx("overrun_pair");
    guard = 0;
    while (mq.size() != 0 && guard < 8) begin
      consume(1);
      guard++;
    end
    check_rx("drained_pair");

    // Five random bytes back to back, none consumed.
    for (int n = 0; n < 5; n++) begin
      rb = 8'($urandom);
      rx_send(rb, 1'b1);
      model_push(rb);
    end
    check_rx("burst5");
    guard = 0;
    while (mq.size() != 0 && guard < 8) begin
      consume(1);
      guard++;
    end
    check_rx("drained_burst");

    // Reset in the middle of a transmission.
    bus.uart_wdata    = 8'h00;
    bus.uart_write_ce = 1'b1;
    tick();
    bus.uart_write_ce = 1'b0;
    repeat (29) tick();
    check("midtx_txd_low", txd, 0);
    check("midtx_busy", bus.send_flag, 0);
    rst = 1'b0;
    #1;
    check("midtx_rst_txd", txd, 1);
    check("midtx_rst_send_flag", bus.send_flag, 1);
    check("midtx_rst_recv_flag", bus.recv_flag, 0);
    mq.delete();
    tick();
    rst = 1'b1;
    tick();
    tx_frame(8'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
